regfile_wr_ctrl: RTL



---
 rtl/regfile_ctrl_pkg.sv | 20 ++
 rtl/rr_arbiter2.sv | 30 +++
 rtl/regfile_wr_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared encodings and constants for the register-file write-port controller.
package regfile_ctrl_pkg;

  localparam int REG_COUNT = 32;

  // The sweep skips x0 (hard-wired zero) and ends at the last register.
  localparam logic [4:0] INIT_FIRST = 5'd1;
  localparam logic [4:0] INIT_LAST  = 5'(REG_COUNT - 1);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_INIT = 1'b1
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_ALU  = 2'd1;
  localparam logic [1:0] GNT_MEM  = 2'd2;
  localparam logic [1:0] GNT_INIT = 2'd3;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. req[0]/gnt[0] is the ALU side, req[1]/gnt[1]
// the load side. After every grant the pointer favours the loser.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic fav_mem_reg;

  // Grant: a lone request always wins; on contention the pointer decides.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = fav_mem_reg ? 2'b10 : 2'b01;
    end
  end

  // Pointer: after a grant, favour whichever side did not win.
  always_ff @(posedge clk) begin
    if (rst) begin
      fav_mem_reg <= 1'b0;
    end else if (advance && (gnt != 2'b00)) begin
      fav_mem_reg <= gnt[0];
    end
  end

endmodule

// File: rtl/regfile_wr_ctrl.sv
// Write-port controller for the 32-entry register file: round-robin sharing
// between ALU and load writeback, x0 suppression, and a zeroing sweep.
module regfile_wr_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         alu_valid,
  output logic         alu_ready,
  input  logic [4:0]   alu_addr,
  input  logic [n-1:0] alu_data,
  input  logic         mem_valid,
  output logic         mem_ready,
  input  logic [4:0]   mem_addr,
  input  logic [n-1:0] mem_data,
  input  logic         init_start,
  output logic         init_busy,
  output logic         regWrite,
  output logic [4:0]   writeAddr,
  output logic [n-1:0] writeData,
  output logic [1:0]   grant
);

  state_t       state_reg, state_next;
  logic [4:0]   cnt_reg, cnt_next;
  logic         wr_reg, wr_next;
  logic [4:0]   addr_reg, addr_next;
  logic [n-1:0] data_reg, data_next;
  logic [1:0]   gnt_reg, gnt_next;

  logic         run_en;
  logic [1:0]   valid_vec;
  logic [1:0]   arb_req;
  logic [1:0]   arb_gnt;

  // Requests are only offered to the arbiter while arbitrating and out of reset,
  // so a handshake can never coincide with reset or the sweep.
  assign run_en    = (state_reg == ST_RUN) && !rst;
  assign valid_vec = {mem_valid, alu_valid};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign arb_req[gi] = valid_vec[gi] & run_en;
    end
  endgenerate

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (arb_req),
    .advance (run_en),
    .gnt     (arb_gnt)
  );

  // A grant only exists for a valid request, so grant == handshake.
  assign alu_ready = arb_gnt[0];
  assign mem_ready = arb_gnt[1];
  assign init_busy = (state_reg == ST_INIT) && !rst;

  assign regWrite  = wr_reg;
  assign writeAddr = addr_reg;
  assign writeData = data_reg;
  assign grant     = gnt_reg;

  // Next-state, sweep counter and next write-port values.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    wr_next    = 1'b0;
    addr_next  = '0;
    data_next  = '0;
    gnt_next   = GNT_NONE;
    case (state_reg)
      ST_RUN: begin
        // Accepted writes to x0 are consumed but never reach the file.
        if (arb_gnt[0] && (alu_addr != 5'd0)) begin
          wr_next   = 1'b1;
          addr_next = alu_addr;
          data_next = alu_data;
          gnt_next  = GNT_ALU;
        end else if (arb_gnt[1] && (mem_addr != 5'd0)) begin
          wr_next   = 1'b1;
          addr_next = mem_addr;
          data_next = mem_data;
          gnt_next  = GNT_MEM;
        end
        if (init_start) begin
          state_next = ST_INIT;
        end
      end
      ST_INIT: begin
        wr_next   = 1'b1;
        addr_next = cnt_reg;
        gnt_next  = GNT_INIT;
        if (cnt_reg == INIT_LAST) begin
          state_next = ST_RUN;
          cnt_next   = INIT_FIRST;
        end else begin
          cnt_next = cnt_reg + 5'd1;
        end
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // State, counter and registered write port; reset abandons any sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_RUN;
      cnt_reg   <= INIT_FIRST;
      wr_reg    <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
      gnt_reg   <= GNT_NONE;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      wr_reg    <= wr_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      gnt_reg   <= gnt_next;
    end
  end

endmodule
